// File: rtl/alu_resp_pkg.sv
// Shared types and the combinational operation decode for the ALU response block.
package alu_resp_pkg;

    // Widest operand the decode function supports; the top may use any W up to this.
    localparam int unsigned MaxW = 32;

    typedef enum logic [1:0] {
        ModeSra = 2'b00,
        ModeShl = 2'b01,
        ModeAdd = 2'b10,
        ModeSub = 2'b11
    } mode_e;

    // One buffered result. Only the low W bits of y are meaningful; upper bits stay zero.
    typedef struct packed {
        logic [MaxW-1:0] y;
        logic            cy;
        logic            ov;
        logic            zr;
    } res_t;

    // Evaluate one operation at run width w (2..MaxW). Operands are zero-extended to MaxW.
    // Work is done one bit wider than MaxW so the add carry-out has a home even at w == MaxW.
    function automatic res_t alu_calc(
        input mode_e           mode,
        input logic [MaxW-1:0] a,
        input logic [MaxW-1:0] b,
        input int unsigned     w
    );
        logic [MaxW:0] one;
        logic [MaxW:0] mask;
        logic [MaxW:0] msb;
        logic [MaxW:0] ea;
        logic [MaxW:0] eb;
        logic [MaxW:0] wide;
        logic          sa;
        logic          sb;
        logic          sy;
        res_t          r;

        one  = (MaxW+1)'(1);
        mask = (one << w) - one;
        msb  = one << (w - 1);
        ea   = {1'b0, a} & mask;
        eb   = {1'b0, b} & mask;
        sa   = |(ea & msb);
        sb   = |(eb & msb);
        r    = '0;
        wide = '0;

        unique case (mode)
            ModeSra: begin
                // Shift right, then replicate the old sign bit back into the top position.
                wide = (eb >> 1) | (eb & msb);
                r.cy = eb[0];
            end
            ModeShl: begin
                wide = (eb << 1) & mask;
                r.cy = sb;
            end
            ModeAdd: begin
                wide = ea + eb;
                r.cy = |(wide & (msb << 1));
                wide = wide & mask;
            end
            ModeSub: begin
                wide = (ea - eb) & mask;
                r.cy = (ea < eb);
            end
            default: begin
                wide = '0;
            end
        endcase

        sy = |(wide & msb);
        if (mode == ModeAdd) begin
            r.ov = (sa == sb) && (sy != sa);
        end else if (mode == ModeSub) begin
            r.ov = (sa != sb) && (sy != sa);
        end else begin
            r.ov = 1'b0;
        end

        r.y  = wide[MaxW-1:0];
        r.zr = (wide == '0);
        return r;
    endfunction

endpackage

// File: rtl/alu_resp_fifo.sv
// Two-entry in-order buffer. Head is always a register; empty slots read as zero.
module alu_resp_fifo #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic full,
    output logic empty
);

    T           head_q;
    T           tail_q;
    logic [1:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = head_q;

    // Storage and occupancy; a push alongside a pop at count 1 lands straight in the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            if (do_pop) begin
                if (cnt_q == 2'd2) begin
                    head_q <= tail_q;
                    tail_q <= '0;
                end else begin
                    head_q <= do_push ? din : '0;
                end
            end else if (do_push) begin
                if (cnt_q == 2'd0) begin
                    head_q <= din;
                end else begin
                    tail_q <= din;
                end
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/alu_resp.sv
// ALU with valid/ready request and response sides, one-cycle latency and a 2-deep result buffer.
module alu_resp
    import alu_resp_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [1:0]       mode,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [W-1:0]     Y,
    output logic             cy,
    output logic             ov,
    output logic             zr,
    output logic [CNT_W-1:0] op_cnt
);

    res_t             res;
    res_t             head;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] op_cnt_q;
    logic             unused_hi_bits;

    assign accept = req_vld && !full;
    assign pop    = rsp_rdy && !empty;

    // Result of the request currently offered; only captured into the buffer on acceptance.
    always_comb begin
        res = alu_calc(mode_e'(mode), MaxW'(A), MaxW'(B), W);
    end

    alu_resp_fifo #(
        .T(res_t)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (accept),
        .pop  (pop),
        .din  (res),
        .head (head),
        .full (full),
        .empty(empty)
    );

    // Count consumed responses, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= '0;
        end else if (pop) begin
            op_cnt_q <= op_cnt_q + 1'b1;
        end
    end

    // All outputs come from registered state, so nothing passes through from the request side.
    assign req_rdy = !full;
    assign rsp_vld = !empty;
    assign Y       = head.y[W-1:0];
    assign cy      = head.cy;
    assign ov      = head.ov;
    assign zr      = head.zr;
    assign op_cnt  = op_cnt_q;

    // Bits above W are always zero by construction.
    assign unused_hi_bits = ^{res.y >> W, head.y >> W};

endmodule

// File: doc/alu_resp.md
ALU_RESP -- requirements
Module: alu_resp

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the completed-operation counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req_vld, input, 1 bit: the request fields are valid.
REQ-006 The block SHALL have port req_rdy, output, 1 bit: the block can accept a request this cycle.
REQ-007 The block SHALL have port A, input, W bits: first operand.
REQ-008 The block SHALL have port B, input, W bits: second operand.
REQ-009 The block SHALL have port mode, input, 2 bits: operation select.
REQ-010 The block SHALL have port rsp_vld, output, 1 bit: a response is presented.
REQ-011 The block SHALL have port rsp_rdy, input, 1 bit: the consumer takes the response.
REQ-012 The block SHALL have port Y, output, W bits: result.
REQ-013 The block SHALL have port cy, output, 1 bit: carry, borrow, or shifted-out bit.
REQ-014 The block SHALL have port ov, output, 1 bit: signed overflow.
REQ-015 The block SHALL have port zr, output, 1 bit: Y is zero.
REQ-016 The block SHALL have port op_cnt, output, CNT_W bits: number of responses consumed.

Function
REQ-017 A request SHALL be accepted in any cycle where req_vld and req_rdy are both 1.
REQ-018 mode 00 SHALL give Y = B shifted right arithmetically by 1, with cy = B[0] and ov = 0.
REQ-019 mode 01 SHALL give Y = B shifted left by 1, with cy = B[W-1] and ov = 0.
REQ-020 mode 10 SHALL give Y = (A+B) mod 2^W, with cy = carry-out and ov = signed add overflow.
REQ-021 mode 11 SHALL give Y = (A-B) mod 2^W, with cy = 1 when A < B unsigned (borrow) and ov = signed subtract overflow.
REQ-022 zr SHALL be 1 exactly when Y is all zero, for every mode.
REQ-023 The result SHALL be computed from the operands captured at acceptance and written into a 2-entry in-order output buffer.
REQ-024 rsp_vld SHALL rise on the clock edge that follows acceptance (latency 1 cycle); the output is never combinationally passed through from the request.
REQ-025 Y, cy, ov and zr SHALL always show the head buffer entry, and SHALL hold stable while rsp_vld=1 and rsp_rdy=0.
REQ-026 A response SHALL be consumed (popped) in any cycle where rsp_vld and rsp_rdy are both 1.
REQ-027 req_rdy SHALL equal (buffer count < 2) and SHALL depend on registered state only.
REQ-028 Push and pop in the same cycle at count 1 SHALL leave count at 1, with the new entry becoming head after the pop.
REQ-029 At count 2, requests SHALL be refused (req_rdy=0); a pop at count 2 raises req_rdy on the next cycle.
REQ-030 When the buffer is empty, rsp_vld SHALL be 0 and Y, cy, ov and zr SHALL be 0.
REQ-031 op_cnt SHALL increment by 1 on each pop and wrap from 2^CNT_W-1 to 0.

Reset
REQ-032 Asserting rst_n low SHALL immediately, without waiting for a clock edge, empty the buffer, drive rsp_vld, Y, cy, ov, zr and op_cnt to 0, and drive req_rdy to 1.
REQ-033 Reset asserted mid-operation SHALL discard all pending and in-flight results with no response emitted.
REQ-034 The first acceptance after reset SHALL be possible in the first clock cycle with rst_n high.

Structure
REQ-035 Package alu_resp_pkg SHALL hold the mode enum (SRA, SHL, ADD, SUB) and the result struct {Y, cy, ov, zr}.
REQ-036 The 2-entry buffer SHALL be a single sub-module, alu_resp_fifo, parameterised on entry type, with push, pop, full, empty and head outputs.
REQ-037 The operation decode SHALL be a combinational function in the package; no further sub-modules.

Verification
REQ-038 A bench SHALL check: mode 00, B=0xAB -> Y=0xD5, cy=1; mode 00, B=0x56 -> Y=0x2B, cy=0; mode 01, B=0x6E -> Y=0xDC, cy=0, ov=0.
REQ-039 A bench SHALL check: mode 10, A=0x95, B=0x6E -> Y=0x03, cy=1, ov=0; A=0x95, B=0x4A -> Y=0xDF, cy=0, ov=0.
REQ-040 A bench SHALL check: mode 11, A=0x9C, B=0x4A -> Y=0x52, cy=0, ov=1; A=0x56, B=0x7D -> Y=0xD9, cy=1, ov=0; A=B=0x33 -> Y=0, zr=1.
REQ-041 A bench SHALL check back-pressure: rsp_rdy=0 with 3 requests offered -> 2 accepted, req_rdy=0, and Y holds the first result; rsp_rdy=1 -> results drain in order and op_cnt=2.
REQ-042 A bench SHALL check streaming: req_vld=1 and rsp_rdy=1 continuously for 10 ops -> one response per cycle after the 1-cycle latency, and op_cnt=10.
REQ-043 A bench SHALL check reset: rst_n pulsed low between clock edges with 2 entries buffered -> rsp_vld=0 and op_cnt=0 immediately, and req_rdy=1.
